// File: rtl/pf_cfg_pkg.sv
// Shared types and constants for the packet-filter config write sequencer.
// Imported by pf_cfg_write_sequencer.
package pf_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP,
    ST_DRAIN
  } pf_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam int         WR_COUNT_W      = 16;

endpackage

// File: rtl/pf_cfg_write_sequencer.sv
// Turns batched (addr,data) commands into single-outstanding AXI-Lite writes.
// Tracks per-batch write count plus sticky response and timeout errors.
module pf_cfg_write_sequencer
  import pf_cfg_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit ABORT_ON_ERR   = 1'b1
) (
  input  logic                  axil_aclk,
  input  logic                  axil_aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [31:0]           cmd_data,
  input  logic                  cmd_last,
  output logic                  m_axil_awvalid,
  output logic [ADDR_W-1:0]     m_axil_awaddr,
  input  logic                  m_axil_awready,
  output logic                  m_axil_wvalid,
  output logic [31:0]           m_axil_wdata,
  input  logic                  m_axil_wready,
  input  logic                  m_axil_bvalid,
  input  logic [1:0]            m_axil_bresp,
  output logic                  m_axil_bready,
  output logic                  busy,
  output logic                  done,
  output logic                  err_resp,
  output logic                  err_timeout,
  output logic [WR_COUNT_W-1:0] wr_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  pf_state_e state, state_d;
  logic [TW-1:0] tmo, tmo_d;
  logic last, last_d;
  logic cmd_ready_d, awvalid_d, wvalid_d, bready_d;
  logic busy_d, done_d, err_resp_d, err_timeout_d;
  logic [ADDR_W-1:0] awaddr_d;
  logic [31:0] wdata_d;
  logic [WR_COUNT_W-1:0] wr_count_d;
  logic cmd_hs;

  assign cmd_hs = cmd_valid && cmd_ready;

  always_comb begin
    state_d       = state;
    tmo_d         = tmo;
    last_d        = last;
    awvalid_d     = m_axil_awvalid;
    wvalid_d      = m_axil_wvalid;
    bready_d      = m_axil_bready;
    awaddr_d      = m_axil_awaddr;
    wdata_d       = m_axil_wdata;
    busy_d        = busy;
    done_d        = 1'b0;
    err_resp_d    = err_resp;
    err_timeout_d = err_timeout;
    wr_count_d    = wr_count;

    // Watchdog saturates and flags, but never retracts AXI valids.
    if (state == ST_ISSUE || state == ST_RESP) begin
      if (tmo != TMO_MAX) tmo_d = tmo + TW'(1);
      if (tmo_d == TMO_MAX) err_timeout_d = 1'b1;
    end

    unique case (state)
      ST_IDLE: begin
        if (cmd_hs) begin
          awaddr_d  = cmd_addr;
          wdata_d   = cmd_data;
          last_d    = cmd_last;
          if (!busy) begin
            wr_count_d    = '0;
            err_resp_d    = 1'b0;
            err_timeout_d = 1'b0;
          end
          busy_d    = 1'b1;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          tmo_d     = '0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_axil_awvalid && m_axil_awready) awvalid_d = 1'b0;
        if (m_axil_wvalid && m_axil_wready) wvalid_d = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_axil_bvalid && m_axil_bready) begin
          if (wr_count != '1) wr_count_d = wr_count + WR_COUNT_W'(1);
          if (m_axil_bresp != AXI_RESP_OKAY) err_resp_d = 1'b1;
          bready_d = 1'b0;
          if (last) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else if (ABORT_ON_ERR && (err_resp_d || err_timeout_d)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (cmd_hs && cmd_last) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      state          <= ST_IDLE;
      tmo            <= '0;
      last           <= 1'b0;
      cmd_ready      <= 1'b0;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_awaddr  <= '0;
      m_axil_wdata   <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_resp       <= 1'b0;
      err_timeout    <= 1'b0;
      wr_count       <= '0;
    end else begin
      state          <= state_d;
      tmo            <= tmo_d;
      last           <= last_d;
      cmd_ready      <= cmd_ready_d;
      m_axil_awvalid <= awvalid_d;
      m_axil_wvalid  <= wvalid_d;
      m_axil_bready  <= bready_d;
      m_axil_awaddr  <= awaddr_d;
      m_axil_wdata   <= wdata_d;
      busy           <= busy_d;
      done           <= done_d;
      err_resp       <= err_resp_d;
      err_timeout    <= err_timeout_d;
      wr_count       <= wr_count_d;
    end
  end

endmodule

// File: tb/tb_pf_cfg_write_sequencer.sv
// Directed bench for pf_cfg_write_sequencer with a simple AXI-Lite slave model.
// Default parameters: TIMEOUT_CYCLES=1024, ABORT_ON_ERR=1.
module tb_pf_cfg_write_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_last = 1'b0;
  logic        awvalid, wvalid, bready;
  logic [31:0] awaddr, wdata;
  logic        awready = 1'b0;
  logic        wready = 1'b0;
  logic        bvalid = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        busy, done, err_resp, err_timeout;
  logic [15:0] wr_count;

  int n_chk = 0;
  int n_err = 0;

  int cyc = 0;
  int aw_stall = 0, w_stall = 0, b_delay = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int aw_hi = 0, w_hi = 0;
  int nb = 0, err_at = -1;
  int done_cnt = 0, exp_done = 0;
  int t_iss = 0, t_to = 0;
  logic bready_at_to = 1'b0;
  logic aw_prev = 1'b0, w_prev = 1'b0, to_prev = 1'b0;
  logic aw_unstable = 1'b0;
  logic [31:0] aw_last = '0;
  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];

  pf_cfg_write_sequencer dut (
    .axil_aclk      (clk),
    .axil_aresetn   (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_data       (cmd_data),
    .cmd_last       (cmd_last),
    .m_axil_awvalid (awvalid),
    .m_axil_awaddr  (awaddr),
    .m_axil_awready (awready),
    .m_axil_wvalid  (wvalid),
    .m_axil_wdata   (wdata),
    .m_axil_wready  (wready),
    .m_axil_bvalid  (bvalid),
    .m_axil_bresp   (bresp),
    .m_axil_bready  (bready),
    .busy           (busy),
    .done           (done),
    .err_resp       (err_resp),
    .err_timeout    (err_timeout),
    .wr_count       (wr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave model and monitor: everything is decided on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (awvalid) begin
        if (!aw_prev) t_iss = cyc;
        if (aw_prev && awaddr != aw_last) aw_unstable = 1'b1;
        aw_last = awaddr;
        aw_hi++;
        awready = (aw_cnt >= aw_stall);
        aw_cnt++;
        if (awready) aw_q.push_back(awaddr);
      end else begin
        awready = 1'b0;
        aw_cnt = 0;
      end
      aw_prev = awvalid;
      if (wvalid) begin
        w_hi++;
        wready = (w_cnt >= w_stall);
        w_cnt++;
        if (wready) w_q.push_back(wdata);
      end else begin
        wready = 1'b0;
        w_cnt = 0;
      end
      w_prev = wvalid;
      if (bready) begin
        b_cnt++;
        if (b_cnt > b_delay && !bvalid) begin
          bvalid = 1'b1;
          bresp = (nb == err_at) ? 2'b10 : 2'b00;
          nb++;
        end
      end else begin
        bvalid = 1'b0;
        bresp = 2'b00;
        b_cnt = 0;
      end
      if (done) done_cnt++;
      if (err_timeout && !to_prev) begin
        t_to = cyc;
        bready_at_to = bready;
      end
      to_prev = err_timeout;
    end
  end

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] d,
                          input logic l);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_data = d;
    cmd_last = l;
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 32'(n < 3000), 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_last = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    exp_done++;
    while (done_cnt < exp_done && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("done_cnt", done_cnt, exp_done);
  endtask

  task automatic clr_log();
    aw_q.delete();
    w_q.delete();
    aw_hi = 0;
    w_hi = 0;
    aw_unstable = 1'b0;
  endtask

  initial begin
    logic [31:0] ea[3];
    logic [31:0] ed[3];
    int nb0, n;
    ea = '{32'h10, 32'h14, 32'h18};
    ed = '{32'hA, 32'hB, 32'hC};

    #12;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wr_count", wr_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_cmd_ready", cmd_ready, 1);

    // 3-command clean batch
    clr_log();
    for (int i = 0; i < 3; i++) send_cmd(ea[i], ed[i], i == 2);
    wait_done();
    chk("b1_aw_n", aw_q.size(), 3);
    chk("b1_w_n", w_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("b1_awaddr", aw_q[i], ea[i]);
      chk("b1_wdata", w_q[i], ed[i]);
    end
    chk("b1_wr_count", wr_count, 3);
    chk("b1_err_resp", err_resp, 0);
    chk("b1_err_timeout", err_timeout, 0);
    chk("b1_busy", busy, 0);

    // AW stalled 3 cycles, W immediate
    clr_log();
    aw_stall = 3;
    nb0 = nb;
    send_cmd(32'h40, 32'h55, 1'b1);
    wait_done();
    aw_stall = 0;
    chk("st_aw_hi", aw_hi, 4);
    chk("st_w_hi", w_hi, 1);
    chk("st_aw_stable", aw_unstable, 0);
    chk("st_b_n", nb - nb0, 1);
    chk("st_awaddr", aw_q[0], 32'h40);
    chk("st_cmd_ready", cmd_ready, 1);
    chk("st_wr_count", wr_count, 1);

    // SLVERR on 2nd of 4 -> drain the rest
    clr_log();
    nb0 = nb;
    err_at = nb + 1;
    for (int i = 0; i < 4; i++)
      send_cmd(32'h20 + 32'(4 * i), 32'h100 + 32'(i), i == 3);
    wait_done();
    err_at = -1;
    chk("ab_err_resp", err_resp, 1);
    chk("ab_aw_n", aw_q.size(), 2);
    chk("ab_w_n", w_q.size(), 2);
    chk("ab_b_n", nb - nb0, 2);
    chk("ab_wr_count", wr_count, 2);
    chk("ab_busy", busy, 0);
    repeat (5) @(negedge clk);
    #1;
    chk("ab_err_sticky", err_resp, 1);

    // B withheld past the watchdog
    clr_log();
    b_delay = 1100;
    send_cmd(32'h80, 32'hDEAD, 1'b1);
    wait_done();
    b_delay = 0;
    chk("to_delay", t_to - t_iss, 1024);
    chk("to_bready", bready_at_to, 1);
    chk("to_err_timeout", err_timeout, 1);
    chk("to_err_resp", err_resp, 0);
    chk("to_wr_count", wr_count, 1);

    // clean batch clears the sticky errors
    clr_log();
    send_cmd(32'h84, 32'h1, 1'b1);
    wait_done();
    chk("cl_err_timeout", err_timeout, 0);
    chk("cl_err_resp", err_resp, 0);
    chk("cl_wr_count", wr_count, 1);

    // reset while waiting on B
    b_delay = 30;
    send_cmd(32'h90, 32'h2, 1'b0);
    send_cmd(32'h94, 32'h3, 1'b1);
    n = 0;
    while (!bready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rr_in_resp", bready, 1);
    chk("rr_wr_count_pre", wr_count, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_bready", bready, 0);
    chk("rr_busy", busy, 0);
    chk("rr_cmd_ready", cmd_ready, 0);
    chk("rr_wr_count", wr_count, 0);
    chk("rr_awaddr", awaddr, 0);
    chk("rr_wdata", wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    b_delay = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rr_post_ready", cmd_ready, 1);
    chk("rr_post_busy", busy, 0);
    chk("rr_post_count", wr_count, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
